alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Upstream control stage for the 16-bit ALU's 6:1 result multiplexer. It accepts one operation per handshake and captures the operands. It drives the 3-bit result select and sequences the multi-cycle multiply and divide units. It presents the mux output as a registered, handshaked result with status.

Parameters:
w, 16, operand and result width
TIMEOUT, 64, max cycles to wait for mul/div done before abort (>= 2)
CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  rising-edge clock, single domain
rst  input  1  synchronous, active-high reset
op_valid  input  1  request valid
op_ready  output  1  sequencer can accept a request
op  input  3  0 add, 1 sub, 2 and, 3 or, 4 mul, 5 div; 6/7 illegal
a_in  input  w  operand A
b_in  input  w  operand B
a_q  output  w  captured operand A, feeds all units
b_q  output  w  captured operand B, feeds all units
sel  output  3  result-mux select
mul_start  output  1  one-cycle start pulse to multiplier
mul_done  input  1  multiplier result valid on its mux input
div_start  output  1  one-cycle start pulse to divider
div_done  input  1  divider result valid
div_by_zero  input  1  divider flag, sampled with div_done
mux_out  input  w  result-mux output
res_valid  output  1  result held valid
res_ready  input  1  consumer accepts result
res  output  w  registered result
err  output  2  0 ok, 1 illegal op, 2 div-by-zero, 3 timeout; valid with res_valid

Behaviour:
- Reset, sync, active-high:
  - state IDLE; op_ready=1, res_valid=0, sel=0, mul_start=0, div_start=0.
  - res=0, err=0, a_q=0, b_q=0, timeout counter=0.
  - rst mid-operation aborts immediately. Late mul_done/div_done arriving in IDLE are ignored.
- Handshake rules:
  - Accept when op_valid & op_ready. a_q, b_q, sel and the op register load that edge.
  - op_ready=1 only in IDLE.
  - Result transfers on res_valid & res_ready. res and err hold stable while res_valid=1 and res_ready=0.
- sel is only ever 0..5. For an illegal op, sel is forced to 0, so the mux never sees an undriven select.
- States:
  - IDLE: on accept with op 0..3, go to EXEC. Op 4/5: go to MC_START. Op 6/7: go to DONE with res=0, err=1, no unit start.
  - EXEC: one cycle for mux settle. Capture res=mux_out, err=0, then go to DONE. Accept-to-res_valid latency is 2 cycles.
  - MC_START: pulse mul_start (op 4) or div_start (op 5) for exactly one cycle. Clear the counter, go to MC_WAIT.
  - MC_WAIT: counter increments each cycle.
    - When the matching done=1: capture res=mux_out. err=2 if div & div_by_zero, else 0. Go to DONE.
    - If the counter reaches TIMEOUT first: res=0, err=3, go to DONE. Done in the same cycle as the counter hitting TIMEOUT counts as done (done wins).
    - The non-matching unit's done is ignored.
  - DONE: res_valid=1. On res_ready, go to IDLE; op_ready rises the next cycle. No back-to-back accept in the transfer cycle.
- sel holds its value from accept through DONE, so the mux stays stable across the whole operation.
- Width: res is exactly w bits. Overflow/carry is not this block's concern.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings OP_ADD..OP_DIV as 3-bit localparams;
  - err codes ERR_OK, ERR_ILLEGAL, ERR_DIVZ, ERR_TIMEOUT;
  - the state encoding.
- One natural sub-module: alu_timeout_counter (clear, enable, TIMEOUT compare, hit output).
- Everything else is one FSM.

Test Plan:
- Reset then op=0, a=0x0003, b=0x0004, mux_out modelled as add -> sel=0 from accept, res_valid 2 cycles after accept, res=0x0007, err=0.
- op=4, a=0x0010, b=0x0003; mul_done asserted 17 cycles after mul_start; res_ready held low 3 cycles -> single mul_start pulse, sel=4 throughout, res=0x0030 held stable until res_ready, err=0.
- op=5, b=0; divider returns div_done with div_by_zero=1 -> err=2, sel=5, no mul_start ever.
- op=6 -> sel stays 0, no start pulses, res_valid 1 cycle after accept, res=0, err=1.
- op=4 with mul_done never asserted, TIMEOUT=64 -> err=3 exactly 64 cycles after MC_WAIT entry. A late mul_done after return to IDLE has no effect.
- rst pulsed during MC_WAIT -> next cycle op_ready=1, res_valid=0, sel=0. A following add completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: op encodings, status
// codes, FSM state encoding and the op-to-select mapping.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;
   localparam logic [2:0] OP_DIV = 3'd5;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_DIVZ    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_EXEC     = 3'd1,
      ST_MC_START = 3'd2,
      ST_MC_WAIT  = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   // Illegal ops map to select 0 so the result mux always sees a driven input.
   function automatic logic [2:0] sel_of_op(input logic [2:0] op);
      logic [2:0] s;
      if (op <= OP_DIV) begin
         s = op;
      end else begin
         s = OP_ADD;
      end
      return s;
   endfunction

endpackage

// File: rtl/alu_timeout_counter.sv
// Cycle counter bounding how long the sequencer waits on a multi-cycle unit.
// hit fires in the enabled cycle whose increment brings the count to TIMEOUT.
module alu_timeout_counter #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_r;

   // Count enabled cycles; clear restarts the window for a new operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en) begin
         cnt_r <= cnt_r + ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign hit = en && (cnt_r == LIMIT_M1);

endmodule

// File: rtl/alu_op_sequencer.sv
// Control stage for the ALU result mux: captures one operation per handshake,
// drives the mux select, sequences the multiplier/divider and returns a
// registered, handshaked result with status.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int w       = 16,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic [2:0]   op,
   input  logic [w-1:0] a_in,
   input  logic [w-1:0] b_in,
   output logic [w-1:0] a_q,
   output logic [w-1:0] b_q,
   output logic [2:0]   sel,
   output logic         mul_start,
   input  logic         mul_done,
   output logic         div_start,
   input  logic         div_done,
   input  logic         div_by_zero,
   input  logic [w-1:0] mux_out,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [w-1:0] res,
   output logic [1:0]   err
);

   state_t         state_r;
   state_t         state_nx_s;
   logic [2:0]     op_r;
   logic [2:0]     sel_r;
   logic [w-1:0]   a_q_r;
   logic [w-1:0]   b_q_r;
   logic [w-1:0]   res_r;
   logic [1:0]     err_r;
   logic           op_ready_r;
   logic           res_valid_r;
   logic           mul_start_r;
   logic           div_start_r;

   logic           accept_s;
   logic           res_ld_s;
   logic [w-1:0]   res_nx_s;
   logic [1:0]     err_nx_s;
   logic           cnt_clr_s;
   logic           cnt_en_s;
   logic           cnt_hit_s;
   logic           is_div_s;
   logic           unit_done_s;

   assign is_div_s    = (op_r == OP_DIV);
   assign unit_done_s = is_div_s ? div_done : mul_done;

   alu_timeout_counter #(
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
   ) u_timeout (
      .clk(clk),
      .rst(rst),
      .clr(cnt_clr_s),
      .en (cnt_en_s),
      .hit(cnt_hit_s)
   );

   // Next-state and result-load decode.
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      res_ld_s   = 1'b0;
      res_nx_s   = '0;
      err_nx_s   = ERR_OK;
      cnt_clr_s  = 1'b0;
      cnt_en_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (op_valid && op_ready_r) begin
               accept_s = 1'b1;
               if (op <= OP_OR) begin
                  state_nx_s = ST_EXEC;
               end else if ((op == OP_MUL) || (op == OP_DIV)) begin
                  state_nx_s = ST_MC_START;
               end else begin
                  state_nx_s = ST_DONE;
                  res_ld_s   = 1'b1;
                  err_nx_s   = ERR_ILLEGAL;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            // Select has been stable for a full cycle; mux output is settled.
            res_ld_s   = 1'b1;
            res_nx_s   = mux_out;
            state_nx_s = ST_DONE;
         end
         ST_MC_START: begin
            cnt_clr_s  = 1'b1;
            state_nx_s = ST_MC_WAIT;
         end
         ST_MC_WAIT: begin
            cnt_en_s = 1'b1;
            // Done is checked before the timeout so a coincident done wins.
            if (unit_done_s) begin
               res_ld_s   = 1'b1;
               res_nx_s   = mux_out;
               err_nx_s   = (is_div_s && div_by_zero) ? ERR_DIVZ : ERR_OK;
               state_nx_s = ST_DONE;
            end else if (cnt_hit_s) begin
               res_ld_s   = 1'b1;
               err_nx_s   = ERR_TIMEOUT;
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_MC_WAIT;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State register, captured operation and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         op_r        <= OP_ADD;
         sel_r       <= 3'd0;
         a_q_r       <= '0;
         b_q_r       <= '0;
         res_r       <= '0;
         err_r       <= ERR_OK;
         op_ready_r  <= 1'b1;
         res_valid_r <= 1'b0;
         mul_start_r <= 1'b0;
         div_start_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         op_ready_r  <= (state_nx_s == ST_IDLE);
         res_valid_r <= (state_nx_s == ST_DONE);
         // MC_START is only entered straight from an accept, so the pulse
         // lasts exactly the one MC_START cycle.
         mul_start_r <= accept_s && (op == OP_MUL);
         div_start_r <= accept_s && (op == OP_DIV);
         if (accept_s) begin
            op_r  <= op;
            sel_r <= sel_of_op(op);
            a_q_r <= a_in;
            b_q_r <= b_in;
         end
         if (res_ld_s) begin
            res_r <= res_nx_s;
            err_r <= err_nx_s;
         end
      end
   end

   assign op_ready  = op_ready_r;
   assign res_valid = res_valid_r;
   assign mul_start = mul_start_r;
   assign div_start = div_start_r;
   assign sel       = sel_r;
   assign a_q       = a_q_r;
   assign b_q       = b_q_r;
   assign res       = res_r;
   assign err       = err_r;

endmodule
